// File: rtl/clock_pkg.sv
// clock_pkg: digit codes, mode encoding and digit-to-code helper shared with the display driver
package clock_pkg;
  localparam logic [3:0] CODE_BLANK = 4'd0;
  localparam logic [3:0] CODE_A = 4'd1;
  localparam logic [3:0] CODE_S = 4'd2;
  localparam logic [3:0] CODE_DIGIT_BASE = 4'd3;
  typedef enum logic [1:0] {RUN, SET_H, SET_M} state_t;
  function automatic logic [3:0] digit_code(input logic [3:0] d);
    return d + CODE_DIGIT_BASE;
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter with arbitrary modulus, synchronous clear and carry-out
module bcd_mod_counter #(
  parameter int MOD = 60,
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);
  localparam logic [3:0] TT = 4'((MOD - 1) / 10);
  localparam logic [3:0] TU = 4'((MOD - 1) % 10);
  localparam logic [3:0] RT = 4'(RST_VAL / 10);
  localparam logic [3:0] RU = 4'(RST_VAL % 10);
  logic term;
  assign term = tens == TT && units == TU;
  assign carry = inc && term;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {tens, units} <= {RT, RU};
    else if (clr) {tens, units} <= 8'h00;
    else if (inc) {tens, units} <= term ? 8'h00 : units == 4'd9 ? {tens + 4'd1, 4'd0} : {tens, units + 4'd1};
endmodule

// File: rtl/clock_time_source.sv
// clock_time_source: 24h HH:MM:SS clock with 1 Hz prescaler, hour/minute set mode and display code word
module clock_time_source
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] display,
  output logic        blink,
  output logic        sec_tick
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic tick, leave, m_inc, h_inc, s_carry, m_carry, unused_h_carry;
  logic [3:0] st, su, mt, mu, ht, hu;
  assign tick = state == RUN && presc == PW'(CLK_HZ - 1);
  assign leave = state == SET_M && btn_mode;
  // minute carry reaches hours only while running, never from the set buttons
  assign m_inc = s_carry || (state == SET_M && btn_inc && !btn_mode);
  assign h_inc = (state == RUN && m_carry) || (state == SET_H && btn_inc && !btn_mode);
  always_comb begin
    state_nx = state;
    if (btn_mode) state_nx = state == RUN ? SET_H : state == SET_H ? SET_M : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      presc <= '0;
      blink <= 1'b0;
      sec_tick <= 1'b0;
      display <= {CODE_BLANK, {5{CODE_DIGIT_BASE}}};
    end else begin
      state <= state_nx;
      presc <= (leave || tick) ? '0 : state == RUN ? presc + 1'b1 : presc;
      blink <= state_nx != RUN;
      sec_tick <= tick;
      display <= {ht == 4'd0 ? CODE_BLANK : digit_code(ht), digit_code(hu), digit_code(mt),
                  digit_code(mu), digit_code(st), digit_code(su)};
    end
  bcd_mod_counter #(.MOD(60), .RST_VAL(0)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(tick), .clr(leave), .tens(st), .units(su), .carry(s_carry)
  );
  bcd_mod_counter #(.MOD(60), .RST_VAL(0)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(m_inc), .clr(1'b0), .tens(mt), .units(mu), .carry(m_carry)
  );
  bcd_mod_counter #(.MOD(24), .RST_VAL(0)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(h_inc), .clr(1'b0), .tens(ht), .units(hu), .carry(unused_h_carry)
  );
endmodule

// File: doc/clock_time_source.md
# clock_time_source

Time-of-day generator that feeds `seven_segment_display`. Keeps a 24-hour HH:MM:SS count advanced by an internal 1 Hz prescaler, supports a two-button hour/minute set mode, and drives the six-digit `display` code word and `blink` request. It is the stage directly upstream of the display driver.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency; the prescaler period in cycles.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `btn_mode` input 1: single-cycle pulse, already debounced and edge-detected upstream; advances mode.
- `btn_inc` input 1: single-cycle pulse, already debounced and edge-detected upstream; increments the selected field.
- `display` output 24: six 4-bit digit codes, [23:20] leftmost. 0 = blank, 1 = 'A', 2 = 'S', 3..12 = digits 0..9 (code = digit + 3).
- `blink` output 1: high while in a set mode.
- `sec_tick` output 1: one-cycle pulse on every seconds increment in RUN.

## Operation
- State machine: RUN -> SET_H -> SET_M -> RUN, advanced by `btn_mode`.
- RUN:
  - Prescaler counts 0..CLK_HZ-1.
  - At CLK_HZ-1: prescaler returns to 0; seconds increment; `sec_tick`=1.
  - Carries: 59 s -> 0 and minutes+1; 59 m -> 0 and hours+1; 23 h -> 0.
- SET_H:
  - Prescaler and seconds frozen.
  - `btn_inc` increments hours, wrapping 23 -> 0.
- SET_M:
  - `btn_inc` increments minutes, wrapping 59 -> 0, with no carry into hours.
- Leaving SET_M to RUN:
  - Seconds cleared to 0 and prescaler cleared to 0.
  - The first tick after exit arrives CLK_HZ cycles after the exit edge.
- `btn_mode` and `btn_inc` in the same cycle: mode wins; inc ignored.
- `btn_inc` in RUN: ignored.
- Counters are held as BCD digit pairs, tens and units; no binary-to-BCD conversion.
- Display mapping, left to right:
  - H-tens: if the value is 0, code 0 (blank); otherwise value+3.
  - Remaining digits: H-units, M-tens, M-units, S-tens, S-units, each digit+3.
- `blink` = (state != RUN).

## Timing
- Reset values:
  - Time 00:00:00, state RUN, prescaler 0.
  - `display`=24'h033333, `blink`=0, `sec_tick`=0.
- `display`, `blink` and `sec_tick` are registered.
- `display` reflects a counter change 1 cycle after the change:
  - tick at cycle N updates the counters at edge N;
  - `display` updates at edge N+1.
- `blink` rises or falls on the edge that registers the state change.
- `sec_tick` is asserted in the same cycle the seconds counter is updated.
- Max ripple: 23:59:59 -> 00:00:00 happens in a single tick, with all digits updating together.
- Reset asserted mid-set: immediate return to the reset values; no partial field retained.
- `btn_inc` on the same cycle as the mode entry into SET_H: ignored, per the mode-wins rule.

## Structure
- Shared package `clock_pkg` holds:
  - the digit-code constants CODE_BLANK=0, CODE_A=1, CODE_S=2, CODE_DIGIT_BASE=3;
  - the state encoding (RUN, SET_H, SET_M);
  - the function digit -> code.
  - `seven_segment_display` is to use the same constants.
- One sub-module, `bcd_mod_counter`:
  - parameters: modulus (60 or 24) and reset value;
  - ports: `clk`, `rst_n`, `inc`, outputs tens[3:0], units[3:0], and `carry`, where carry = inc while at the terminal count;
  - instantiated three times: seconds, minutes, hours.
  - Hours mod 24 wraps on tens=2, units=3, not on units=9.

## Test plan
- Reset, CLK_HZ=4: hold `rst_n`=0 -> `display`=24'h033333, `blink`=0. Release and run 16 cycles -> seconds reach 04; `display`=24'h033337; exactly four `sec_tick` pulses, spaced 4 cycles apart.
- Full rollover: preset 23:59:59 via set mode plus ticks, then one tick -> `display`=24'h033333 one cycle after `sec_tick`.
- Set hours:
  - Sequence: `btn_mode`, then `btn_inc` ×25 -> hours=01, `blink`=1, seconds frozen over 100 cycles.
  - Then `btn_mode`, `btn_inc` ×61 -> minutes=01, hours unchanged.
- Exit set: from 05:07:42, press `btn_mode` twice to reach SET_M, then press it again -> state RUN, `blink`=0, seconds=00; first `sec_tick` exactly CLK_HZ cycles later.
- Simultaneous buttons: `btn_mode` and `btn_inc` asserted together in SET_H -> state SET_M, hours unchanged. `btn_inc` alone in RUN -> no change.
- Reset mid-operation: assert `rst_n`=0 asynchronously (between clock edges) while in SET_M at 12:34 -> outputs return to the reset values without waiting for a clock edge.
